// File: rtl/posit_pkg.sv
// Shared posit definitions: widths, special encodings, FSM states
// and the regime/exponent scale helper.
package posit_pkg;

    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int N  = 32;
    localparam int ES = 2;
    localparam int M  = N - ES;
    localparam int BS = log2(N);
    // signed scale width
    localparam int SW = BS + ES + 2;
    // product and fraction widths
    localparam int PW = 2 * (M + 1);
    localparam int FW = PW - 1;
    // iteration counter width
    localparam int CW = 5;

    localparam logic [N-1:0] POSIT_ZERO = '0;
    localparam logic [N-1:0] POSIT_NAR  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] MAXPOS     = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MINPOS     = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        MULT,
        ROUND,
        DONE
    } state_t;

    function automatic logic signed [SW-1:0] scale_of(
        input logic          rc,
        input logic [BS-1:0] k,
        input logic [ES-1:0] e
    );
        logic signed [SW-1:0] r;
        r = rc ? $signed(SW'(k)) : -$signed(SW'(k));
        return (r <<< ES) + $signed(SW'(e));
    endfunction

endpackage

// File: rtl/bct_posit_mul_seq_if.sv
// Request/response bundle of the sequential posit multiplier.
// master drives start/operands, slave returns busy/out/done.
interface bct_posit_mul_seq_if;
    import posit_pkg::*;

    logic         start;
    logic [N-1:0] in1;
    logic [N-1:0] in2;
    logic         busy;
    logic [N-1:0] out;
    logic         done;

    modport master (
        output start, in1, in2,
        input  busy, out, done
    );

    modport slave (
        input  start, in1, in2,
        output busy, out, done
    );

endinterface

// File: rtl/bct_posit_encode_rnd.sv
// Combinational posit encoder: sign/scale/fraction to N-bit posit
// with regime shift, round-to-nearest-even and saturation.
module bct_posit_encode_rnd
    import posit_pkg::*;
(
    input  logic                 sign,
    input  logic signed [SW-1:0] sc,
    input  logic [FW-1:0]        frac,
    output logic [N-1:0]         posit
);

    localparam int BW = N - 1;
    localparam int XW = 2 + ES + FW;
    localparam int YW = XW + BW;
    localparam logic signed [SW-1:0] KMAX = SW'(N - 2);
    localparam logic signed [SW-1:0] KMIN = SW'(-(N - 1));

    logic signed [SW-1:0] k;
    logic [SW-1:0]        sh;
    logic [YW-1:0]        y;
    logic [YW-1:0]        ys;
    logic [BW-1:0]        body;
    logic [BW-1:0]        body_r;
    logic                 guard;
    logic                 sticky;
    logic                 up;
    logic [N-1:0]         mag;

    // regime pattern is pre-seeded so the arithmetic shift
    // extends the run with the correct fill bit
    always_comb begin
        k      = sc >>> ES;
        sh     = k[SW-1] ? ~k : k;
        y      = {~k[SW-1], k[SW-1], sc[ES-1:0], frac,
                  {BW{1'b0}}};
        ys     = $signed(y) >>> sh;
        body   = ys[YW-1 -: BW];
        guard  = ys[YW-N];
        sticky = |ys[YW-N-1:0];
        up     = guard & (sticky | body[0]);
        body_r = body + BW'(up);
        mag    = {1'b0, body_r};
        if (k >= KMAX) mag = MAXPOS;
        else if (k <= KMIN) mag = MINPOS;
        posit  = sign ? -mag : mag;
    end

endmodule

// File: rtl/data_extract_v1.sv
// Splits a non-negative posit body into regime run, exponent
// and left-aligned mantissa (hidden bit excluded).
module data_extract_v1
    import posit_pkg::*;
(
    input  logic [N-2:0]  body,
    output logic          rc,
    output logic [BS-1:0] regime,
    output logic [ES-1:0] exp,
    output logic [M-1:0]  mant
);

    logic [BS:0]  len;
    logic         stop;
    logic [N-2:0] rest;

    // measure the regime run, then strip run + terminator
    always_comb begin
        rc   = body[N-2];
        len  = '0;
        stop = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!stop && (body[i] == rc)) len = len + 1'b1;
            else stop = 1'b1;
        end
        rest   = body << len;
        rest   = rest << 1;
        exp    = rest[N-2 -: ES];
        mant   = {rest[N-2-ES:0], 1'b0};
        regime = rc ? BS'(len - 1'b1) : BS'(len);
    end

endmodule

// File: rtl/bct_posit_mul_seq.sv
// Multi-cycle posit multiplier: decode, shift-add, round/encode.
// POSIT_MUL_EARLY_DONE_EN: special operands skip the MULT phase.
module bct_posit_mul_seq
    import posit_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    bct_posit_mul_seq_if.slave  bus
);

    localparam int BW = N - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(M);

    state_t state;
    state_t state_nxt;

    logic [N-1:0]         op1;
    logic [N-1:0]         op2;
    logic                 sign_q;
    logic                 nar_q;
    logic                 zero_q;
    logic signed [SW-1:0] sc_q;
    logic [M:0]           mcand;
    logic [PW-1:0]        acc;
    logic [CW-1:0]        cnt;
    logic [N-1:0]         out_q;

    logic [BW-1:0]        abs1;
    logic [BW-1:0]        abs2;
    logic                 rc1;
    logic                 rc2;
    logic [BS-1:0]        k1;
    logic [BS-1:0]        k2;
    logic [ES-1:0]        e1;
    logic [ES-1:0]        e2;
    logic [M-1:0]         m1;
    logic [M-1:0]         m2;
    logic                 nar_d;
    logic                 zero_d;
    logic [M+1:0]         psum;
    logic [FW-1:0]        frac;
    logic signed [SW-1:0] sc_fin;
    logic [N-1:0]         enc;

    assign abs1 = op1[N-1] ? BW'(-op1) : op1[BW-1:0];
    assign abs2 = op2[N-1] ? BW'(-op2) : op2[BW-1:0];

    assign nar_d  = (op1 == POSIT_NAR) || (op2 == POSIT_NAR);
    assign zero_d = (op1 == POSIT_ZERO) || (op2 == POSIT_ZERO);

    data_extract_v1 u_ext1 (
        .body   (abs1),
        .rc     (rc1),
        .regime (k1),
        .exp    (e1),
        .mant   (m1)
    );

    data_extract_v1 u_ext2 (
        .body   (abs2),
        .rc     (rc2),
        .regime (k2),
        .exp    (e2),
        .mant   (m2)
    );

    assign psum = {1'b0, acc[PW-1:M+1]}
                + (acc[0] ? {1'b0, mcand} : '0);

    // product >= 2 bumps the scale and drops one more MSB
    assign frac = acc[PW-1] ? acc[PW-2:0]
                            : {acc[PW-3:0], 1'b0};
    assign sc_fin = sc_q
                  + $signed({{(SW-1){1'b0}}, acc[PW-1]});

    bct_posit_encode_rnd u_enc (
        .sign  (sign_q),
        .sc    (sc_fin),
        .frac  (frac),
        .posit (enc)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    // next state and status outputs
    always_comb begin
        state_nxt = state;
        bus.busy  = 1'b1;
        bus.done  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = DECODE;
            end
            DECODE: begin
`ifdef POSIT_MUL_EARLY_DONE_EN
                if (nar_d || zero_d) state_nxt = ROUND;
                else state_nxt = MULT;
`else
                state_nxt = MULT;
`endif
            end
            MULT: begin
                if (cnt == CNT_LAST) state_nxt = ROUND;
            end
            ROUND: state_nxt = DONE;
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // operand capture, decode, shift-add and result latch
    always_ff @(posedge clock) begin
        if (reset) begin
            op1    <= '0;
            op2    <= '0;
            sign_q <= 1'b0;
            nar_q  <= 1'b0;
            zero_q <= 1'b0;
            sc_q   <= '0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            out_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        op1 <= bus.in1;
                        op2 <= bus.in2;
                    end
                end
                DECODE: begin
                    sign_q <= op1[N-1] ^ op2[N-1];
                    nar_q  <= nar_d;
                    zero_q <= zero_d;
                    sc_q   <= scale_of(rc1, k1, e1)
                            + scale_of(rc2, k2, e2);
                    mcand  <= {1'b1, m1};
                    acc    <= {{(M+1){1'b0}}, 1'b1, m2};
                    cnt    <= '0;
                end
                MULT: begin
                    acc <= {psum, acc[M:1]};
                    cnt <= cnt + 1'b1;
                end
                ROUND: begin
                    if (nar_q) out_q <= POSIT_NAR;
                    else if (zero_q) out_q <= POSIT_ZERO;
                    else out_q <= enc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_bct_posit_mul_seq.sv
// Self-checking bench for bct_posit_mul_seq: directed vectors,
// random operands against a bit-string posit model, protocol cases.
module tb_bct_posit_mul_seq;
    import posit_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bct_posit_mul_seq_if bus ();

    bct_posit_mul_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic void pdecode(
        input  logic [31:0] p,
        output bit          s,
        output int          sc,
        output longint      f
    );
        logic [31:0] a;
        bit          rc;
        int          i, run, k, e, nf;
        longint      fr;
        s   = p[31];
        a   = s ? -p : p;
        rc  = a[30];
        run = 0;
        i   = 30;
        while (i >= 0 && a[i] == rc) begin
            run++;
            i--;
        end
        k = rc ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < 2; j++) begin
            e = e * 2 + ((i >= 0) ? int'(a[i]) : 0);
            i--;
        end
        fr = 0;
        nf = 0;
        while (i >= 0) begin
            fr = fr * 2 + longint'(a[i]);
            nf++;
            i--;
        end
        f  = (longint'(1) << 27) | (fr << (27 - nf));
        sc = 4 * k + e;
    endfunction

    // value = 1.fr (nfb fraction bits) * 2^sc, rounded on the
    // infinite posit bit string
    function automatic logic [31:0] pencode(
        input bit     s,
        input int     sc,
        input longint fr,
        input int     nfb
    );
        bit          q[$];
        int          k, e;
        logic [31:0] body;
        bit          g, st;
        k = (sc >= 0) ? sc / 4 : -((-sc + 3) / 4);
        e = sc - 4 * k;
        if (k >= 30) body = 32'h7FFFFFFF;
        else if (k <= -31) body = 32'h00000001;
        else begin
            if (k >= 0) begin
                repeat (k + 1) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                repeat (-k) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            q.push_back(e[1]);
            q.push_back(e[0]);
            for (int j = nfb - 1; j >= 0; j--) q.push_back(fr[j]);
            while (q.size() < 33) q.push_back(1'b0);
            body = 0;
            for (int j = 0; j < 31; j++) body = {body[30:0], q[j]};
            g  = q[31];
            st = 1'b0;
            for (int j = 32; j < q.size(); j++) st |= q[j];
            if (g && (st || body[0])) body = body + 1;
        end
        return s ? -body : body;
    endfunction

    function automatic logic [31:0] model_mul(
        input logic [31:0] a,
        input logic [31:0] b
    );
        bit     s1, s2;
        int     c1, c2, sc;
        longint f1, f2, p;
        if (a == 32'h80000000 || b == 32'h80000000)
            return 32'h80000000;
        if (a == 0 || b == 0) return 32'h0;
        pdecode(a, s1, c1, f1);
        pdecode(b, s2, c2, f2);
        p  = f1 * f2;
        sc = c1 + c2;
        if (p >= (longint'(1) << 55)) begin
            return pencode(s1 ^ s2, sc + 1,
                           p - (longint'(1) << 55), 55);
        end
        return pencode(s1 ^ s2, sc, p - (longint'(1) << 54), 54);
    endfunction

    function automatic int exp_lat(
        input logic [31:0] a,
        input logic [31:0] b
    );
        bit sp;
        bit early;
        sp = (a == 32'h80000000) || (b == 32'h80000000)
          || (a == 0) || (b == 0);
        early = 1'b0;
`ifdef POSIT_MUL_EARLY_DONE_EN
        early = 1'b1;
`endif
        return (early && sp) ? 3 : M + 4;
    endfunction

    function automatic logic [31:0] rnd_posit();
        logic [31:0] v;
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0: v = 32'h80000000;
            1: v = 32'h0;
            2: v = $urandom >> $urandom_range(1, 31);
            3: v = 32'h7FFFFFFF ^ ($urandom >> $urandom_range(1, 31));
            default: v = $urandom;
        endcase
        if ((sel == 2 || sel == 3) && $urandom_range(0, 1) == 1)
            v = -v;
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic run_op(
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] r,
        output int          lat
    );
        @(negedge clock);
        bus.start = 1'b1;
        bus.in1   = a;
        bus.in2   = b;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        r = bus.out;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", bus.done);
        end
        checks++;
        if (bus.out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got %h want 0", bus.out);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [12];
        logic [31:0] tb [12];
        logic [31:0] te [12];
        logic [31:0] r;
        int lat;
        ta = '{32'h40000000, 32'h48000000, 32'h44000000,
               32'h40000000, 32'hC0000000, 32'h80000000,
               32'h00000000, 32'h7FFFFFFF, 32'h00000001,
               32'h80000000, 32'h80000001, 32'hFFFFFFFF};
        tb = '{32'h40000000, 32'h48000000, 32'h44000000,
               32'hC0000000, 32'hC0000000, 32'h00000000,
               32'h48000000, 32'h7FFFFFFF, 32'h00000001,
               32'h40000000, 32'h7FFFFFFF, 32'h00000001};
        te = '{32'h40000000, 32'h50000000, 32'h49000000,
               32'hC0000000, 32'h40000000, 32'h80000000,
               32'h00000000, 32'h7FFFFFFF, 32'h00000001,
               32'h80000000, 32'h80000001, 32'hFFFFFFFF};
        for (int i = 0; i < 12; i++) begin
            run_op(ta[i], tb[i], r, lat);
            checks++;
            if (r !== te[i]) begin
                errors++;
                $display("FAIL dir%0d %h*%h got %h want %h",
                         i, ta[i], tb[i], r, te[i]);
            end
            checks++;
            if (lat != exp_lat(ta[i], tb[i])) begin
                errors++;
                $display("FAIL dir%0d_lat got %0d want %0d",
                         i, lat, exp_lat(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r, e;
        int lat;
        for (int i = 0; i < 200; i++) begin
            a = rnd_posit();
            b = rnd_posit();
            e = model_mul(a, b);
            run_op(a, b, r, lat);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL rand %h*%h got %h want %h",
                         a, b, r, e);
            end
            checks++;
            if (lat != exp_lat(a, b)) begin
                errors++;
                $display("FAIL rand_lat %h*%h got %0d want %0d",
                         a, b, lat, exp_lat(a, b));
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] a, b, prev, e;
        int lat, extra;
        a = 32'h44000000;
        b = 32'h48000000;
        e = model_mul(a, b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.in1   = a;
        bus.in2   = b;
        @(negedge clock);
        bus.start = 1'b0;
        lat  = 1;
        prev = bus.out;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %b want 1", bus.busy);
        end
        while (lat < 10) begin
            @(negedge clock);
            lat++;
        end
        bus.start = 1'b1;
        bus.in1   = 32'h7FFFFFFF;
        bus.in2   = 32'h00000001;
        @(negedge clock);
        lat++;
        bus.start = 1'b0;
        checks++;
        if (bus.out !== prev) begin
            errors++;
            $display("FAIL ign_out got %h want %h", bus.out, prev);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL ign_busy got %b want 1", bus.busy);
        end
        while (!bus.done && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        checks++;
        if (bus.out !== e) begin
            errors++;
            $display("FAIL ign_result got %h want %h", bus.out, e);
        end
        checks++;
        if (lat != M + 4) begin
            errors++;
            $display("FAIL ign_lat got %0d want %0d", lat, M + 4);
        end
        extra = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus.done) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ign_queued got %0d done want 0", extra);
        end
    endtask

    task automatic test_reset_abort();
        int lat, pulses;
        @(negedge clock);
        bus.start = 1'b1;
        bus.in1   = 32'h44000000;
        bus.in2   = 32'h44000000;
        @(negedge clock);
        bus.start = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge clock);
            lat++;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got %b want 0", bus.busy);
        end
        checks++;
        if (bus.out !== 32'h0) begin
            errors++;
            $display("FAIL abort_out got %h want 0", bus.out);
        end
        @(negedge clock);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.in1   = 32'h48000000;
        bus.in2   = 32'h48000000;
        @(negedge clock);
        reset     = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_busy got %b want 0", bus.busy);
        end
        pulses = 0;
        repeat (45) begin
            @(negedge clock);
            if (bus.done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_done got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, r, e;
        int lat;
        for (int i = 0; i < 4; i++) begin
            a = rnd_posit();
            b = rnd_posit();
            e = model_mul(a, b);
            run_op(a, b, r, lat);
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL b2b%0d %h*%h got %h want %h",
                         i, a, b, r, e);
            end
            checks++;
            if (lat != exp_lat(a, b)) begin
                errors++;
                $display("FAIL b2b%0d_lat got %0d want %0d",
                         i, lat, exp_lat(a, b));
            end
        end
        repeat (6) @(negedge clock);
        checks++;
        if (bus.out !== e) begin
            errors++;
            $display("FAIL hold_out got %h want %h", bus.out, e);
        end
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
